// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
package muldiv_pkg;

  localparam int MULDIV_XLEN    = 32;
  // Cycles from the accept edge to the result pulse on the iterating path.
  localparam int MULDIV_LATENCY = MULDIV_XLEN + 1;

  // Values follow the funct3 field of the M-extension instructions.
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_e;

  // rs1 is interpreted as signed for these operations.
  function automatic logic a_is_signed(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // rs2 is interpreted as signed for these operations.
  function automatic logic b_is_signed(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Combinational sign handling: operand magnitudes on the way in, two's
// complement fixup of the double-width raw result on the way out.
module muldiv_signfix
  import muldiv_pkg::*;
#(
  parameter int XLEN = MULDIV_XLEN
) (
  input  logic [2:0]        op,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [XLEN-1:0]   a_mag,
  output logic [XLEN-1:0]   b_mag,
  output logic              a_neg,
  output logic              b_neg,
  input  logic [2*XLEN-1:0] res_raw,
  input  logic              res_negate,
  output logic [2*XLEN-1:0] res_fixed
);

  localparam logic [XLEN-1:0]   ONE_X  = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [2*XLEN-1:0] ONE_2X = {{(2*XLEN-1){1'b0}}, 1'b1};

  muldiv_op_e op_e;
  assign op_e = muldiv_op_e'(op);

  // Operand sign flags and absolute values; unsigned operands pass through.
  always_comb begin
    a_neg = a_is_signed(op_e) & a[XLEN-1];
    b_neg = b_is_signed(op_e) & b[XLEN-1];
    a_mag = a_neg ? (~a + ONE_X) : a;
    b_mag = b_neg ? (~b + ONE_X) : b;
  end

  // Full-width negation so the high half of a negative product is correct.
  always_comb begin
    res_fixed = res_negate ? (~res_raw + ONE_2X) : res_raw;
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: one op at a time, XLEN
// shift-add or restoring-divide iterations, result as a one-cycle pulse.
//
// Handshake: an op is accepted on a rising edge where start=1, in_ready=1 and
// kill=0; a, b and op are sampled on that edge only. The result appears with
// out_valid=1 for exactly one cycle (DONE) and there is no back-pressure.
// kill in CALC or DONE discards the op and suppresses out_valid at once.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN      = MULDIV_XLEN,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            in_ready,
  output logic            busy,
  output logic            out_valid,
  output logic [XLEN-1:0] result
);

  localparam int              CNT_W    = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e     state;
  muldiv_op_e        op_q;
  logic [2*XLEN-1:0] acc;       // mul: {partial high, multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0]   opb_q;     // multiplicand or divisor magnitude
  logic              a_neg_q;
  logic              b_neg_q;
  logic              dz_q;      // divisor was zero: quotient keeps its all-ones value
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   res_q;

  logic              accept;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic              a_neg;
  logic              b_neg;
  logic [2*XLEN-1:0] acc_next;
  logic [XLEN:0]     sum;
  logic [XLEN:0]     diff;
  logic [2*XLEN-1:0] res_raw;
  logic              res_negate;
  logic [2*XLEN-1:0] res_fixed;
  logic [XLEN-1:0]   final_res;
  logic              early_hit;
  logic [XLEN-1:0]   early_res;

  assign in_ready  = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign out_valid = (state == ST_DONE) && !kill;
  assign result    = res_q;
  assign accept    = start && in_ready && !kill;

  muldiv_signfix #(.XLEN(XLEN)) u_signfix (
    .op         (op),
    .a          (a),
    .b          (b),
    .a_mag      (a_mag),
    .b_mag      (b_mag),
    .a_neg      (a_neg),
    .b_neg      (b_neg),
    .res_raw    (res_raw),
    .res_negate (res_negate),
    .res_fixed  (res_fixed)
  );

  // One loop iteration: shift-add for multiply, restoring step for divide.
  always_comb begin
    acc_next = acc;
    sum      = '0;
    diff     = '0;
    if (op_q[2]) begin
      // Remainder shifted left with the next dividend bit, minus divisor.
      diff = acc[2*XLEN-1:XLEN-1] - {1'b0, opb_q};
      if (!diff[XLEN]) begin
        acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      end else begin
        acc_next = {acc[2*XLEN-2:0], 1'b0};
      end
    end else begin
      sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb_q} : '0);
      acc_next = {sum, acc[XLEN-1:1]};
    end
  end

  // Pick the result half from the final iteration and decide its sign.
  always_comb begin
    res_raw    = acc_next;
    res_negate = a_neg_q ^ b_neg_q;
    if (op_q[2]) begin
      if (op_q[1]) begin
        res_raw    = {{XLEN{1'b0}}, acc_next[2*XLEN-1:XLEN]};
        res_negate = a_neg_q;
      end else begin
        res_raw    = {{XLEN{1'b0}}, acc_next[XLEN-1:0]};
        res_negate = (a_neg_q ^ b_neg_q) & ~dz_q;
      end
    end
    if (op_q[2] || (op_q == OP_MUL)) begin
      final_res = res_fixed[XLEN-1:0];
    end else begin
      final_res = res_fixed[2*XLEN-1:XLEN];
    end
  end

  // Divide-by-zero and signed overflow answers for the early-out path.
  always_comb begin
    early_hit = 1'b0;
    early_res = '0;
    if (EARLY_OUT && op[2]) begin
      if (b == '0) begin
        early_hit = 1'b1;
        early_res = op[1] ? a : ALL_ONES;
      end else if (!op[0] && (a == INT_MIN) && (b == ALL_ONES)) begin
        early_hit = 1'b1;
        early_res = op[1] ? '0 : INT_MIN;
      end
    end
  end

  // Sequencer FSM and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      op_q    <= OP_MUL;
      acc     <= '0;
      opb_q   <= '0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      dz_q    <= 1'b0;
      cnt     <= '0;
      res_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q    <= muldiv_op_e'(op);
            opb_q   <= b_mag;
            a_neg_q <= a_neg;
            b_neg_q <= b_neg;
            dz_q    <= (b == '0);
            cnt     <= '0;
            acc     <= {{XLEN{1'b0}}, a_mag};
            if (early_hit) begin
              res_q <= early_res;
              state <= ST_DONE;
            end else begin
              state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (kill) begin
            state <= ST_IDLE;
          end else begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              res_q <= final_res;
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: one instance with early-out enabled and one
// without, driven by the same stimulus and checked against hand-computed values.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        kill;

  logic        in_ready0, busy0, out_valid0;
  logic [31:0] result0;
  logic        in_ready1, busy1, out_valid1;
  logic [31:0] result1;

  int checks   = 0;
  int failures = 0;

  muldiv_seq #(.XLEN(32), .EARLY_OUT(1'b1)) dut_eo (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .kill(kill),
    .in_ready(in_ready0), .busy(busy0), .out_valid(out_valid0), .result(result0)
  );

  muldiv_seq #(.XLEN(32), .EARLY_OUT(1'b0)) dut_it (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .kill(kill),
    .in_ready(in_ready1), .busy(busy1), .out_valid(out_valid1), .result(result1)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op in cycle 0 and watch both instances for 40 cycles.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] exp_res,
                        input int lat_eo, input int lat_it, input bit poke);
    int first0, first1, n0, n1;
    logic [31:0] r0, r1;
    first0 = -1; first1 = -1; n0 = 0; n1 = 0; r0 = '0; r1 = '0;
    start = 1'b1; op = o; a = av; b = bv;
    step();
    start = 1'b0; a = $urandom; b = $urandom;
    check({tag, " in_ready_c1"}, {30'b0, in_ready0, in_ready1}, 32'h0);
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) step();
      if (out_valid0) begin
        if (n0 == 0) begin first0 = c; r0 = result0; end
        n0++;
      end
      if (out_valid1) begin
        if (n1 == 0) begin first1 = c; r1 = result1; end
        n1++;
      end
      start = poke && (c >= 3) && (c <= 6);
    end
    start = 1'b0;
    check({tag, " eo_latency"}, 32'(first0), 32'(lat_eo));
    check({tag, " eo_result"}, r0, exp_res);
    check({tag, " eo_pulses"}, 32'(n0), 32'd1);
    check({tag, " it_latency"}, 32'(first1), 32'(lat_it));
    check({tag, " it_result"}, r1, exp_res);
    check({tag, " it_pulses"}, 32'(n1), 32'd1);
    check({tag, " eo_held"}, result0, exp_res);
  endtask

  // Directed sequence
  initial begin
    int nk0, nk1, first0, first1;
    logic [31:0] r0, r1;
    reset = 1'b1; start = 1'b0; kill = 1'b0; op = 3'd0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset in_ready", {30'b0, in_ready0, in_ready1}, 32'h3);
    check("reset busy", {30'b0, busy0, busy1}, 32'h0);
    check("reset out_valid", {30'b0, out_valid0, out_valid1}, 32'h0);
    check("reset result_eo", result0, 32'h0);
    check("reset result_it", result1, 32'h0);
    reset = 1'b0;
    step();

    run_op("mul",    OP_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, MULDIV_LATENCY, MULDIV_LATENCY, 1'b1);
    run_op("mulh",   OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MULDIV_LATENCY, MULDIV_LATENCY, 1'b0);
    run_op("mulhu",  OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MULDIV_LATENCY, MULDIV_LATENCY, 1'b0);
    run_op("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULDIV_LATENCY, MULDIV_LATENCY, 1'b0);
    run_op("div",    OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, MULDIV_LATENCY, MULDIV_LATENCY, 1'b1);
    run_op("rem",    OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, MULDIV_LATENCY, MULDIV_LATENCY, 1'b0);
    run_op("divu",   OP_DIVU,   32'd100,       32'd7,         32'd14,        MULDIV_LATENCY, MULDIV_LATENCY, 1'b0);
    run_op("remu",   OP_REMU,   32'd100,       32'd7,         32'd2,         MULDIV_LATENCY, MULDIV_LATENCY, 1'b0);
    run_op("div_by0",  OP_DIV,  32'd5,         32'd0,         32'hFFFF_FFFF, 1, MULDIV_LATENCY, 1'b0);
    run_op("remu_by0", OP_REMU, 32'd5,         32'd0,         32'd5,         1, MULDIV_LATENCY, 1'b0);
    run_op("div_ovf",  OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, MULDIV_LATENCY, 1'b0);
    run_op("rem_ovf",  OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1, MULDIV_LATENCY, 1'b0);

    // Kill a DIVU in cycle 10, then start MUL 3x4 in cycle 11.
    nk0 = 0; nk1 = 0; first0 = -1; first1 = -1; r0 = '0; r1 = '0;
    start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
    step();
    start = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      if (c > 1) step();
      if (c <= 11) begin
        if (out_valid0) nk0++;
        if (out_valid1) nk1++;
      end else begin
        if (out_valid0 && first0 < 0) begin first0 = c; r0 = result0; end
        if (out_valid1 && first1 < 0) begin first1 = c; r1 = result1; end
      end
      if (c == 10) kill = 1'b1;
      if (c == 11) begin
        check("kill in_ready_c11", {30'b0, in_ready0, in_ready1}, 32'h3);
        kill = 1'b0; start = 1'b1; op = OP_MUL; a = 32'd3; b = 32'd4;
      end
      if (c == 12) start = 1'b0;
    end
    check("kill no_valid_eo", 32'(nk0), 32'd0);
    check("kill no_valid_it", 32'(nk1), 32'd0);
    check("restart latency_eo", 32'(first0), 32'd44);
    check("restart latency_it", 32'(first1), 32'd44);
    check("restart result_eo", r0, 32'd12);
    check("restart result_it", r1, 32'd12);

    // Kill while in DONE suppresses the pulse in that same cycle.
    start = 1'b1; op = OP_MUL; a = 32'd5; b = 32'd6;
    step();
    start = 1'b0;
    for (int c = 2; c <= 33; c++) step();
    check("done valid_c33", {30'b0, out_valid0, out_valid1}, 32'h3);
    kill = 1'b1;
    #1;
    check("done kill_valid", {30'b0, out_valid0, out_valid1}, 32'h0);
    step();
    kill = 1'b0;
    check("done kill in_ready", {30'b0, in_ready0, in_ready1}, 32'h3);
    check("done kill out_valid", {30'b0, out_valid0, out_valid1}, 32'h0);

    // start and kill together in IDLE: nothing accepted.
    start = 1'b1; kill = 1'b1; op = OP_MUL; a = 32'd1; b = 32'd1;
    step();
    start = 1'b0; kill = 1'b0;
    check("start_kill in_ready", {30'b0, in_ready0, in_ready1}, 32'h3);
    check("start_kill busy", {30'b0, busy0, busy1}, 32'h0);

    // Asynchronous reset in cycle 5 of a multiply.
    start = 1'b1; op = OP_MUL; a = 32'd9; b = 32'd9;
    step();
    start = 1'b0;
    for (int c = 2; c <= 5; c++) step();
    check("pre_reset busy", {30'b0, busy0, busy1}, 32'h3);
    #2;
    reset = 1'b1;
    #1;
    check("areset busy", {30'b0, busy0, busy1}, 32'h0);
    check("areset in_ready", {30'b0, in_ready0, in_ready1}, 32'h3);
    check("areset out_valid", {30'b0, out_valid0, out_valid1}, 32'h0);
    check("areset result_eo", result0, 32'h0);
    check("areset result_it", result1, 32'h0);
    #1;
    reset = 1'b0;
    nk0 = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (out_valid0 || out_valid1) nk0++;
    end
    check("post_reset no_valid", 32'(nk0), 32'd0);

    run_op("mul_after_reset", OP_MUL, 32'h1234_5678, 32'h10, 32'h2345_6780, MULDIV_LATENCY, MULDIV_LATENCY, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer for the RV32M extension.
- Sits beside the single-cycle ALU in the execute stage.
- Accepts one operation through a start/ready handshake, runs a 32-iteration shift-add or restoring-divide loop, and returns the result as a one-cycle valid pulse.
- The execute stage holds its stall asserted while the sequencer is busy. A flush from the execute stage can abort the operation.

Parameters:
- XLEN, 32, operand/result width; the iteration count equals XLEN.
- EARLY_OUT, 1, when 1, divide-by-zero and signed overflow complete in 1 cycle without iterating.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  request; accepted only when in_ready=1 and kill=0
- op  in  3  muldiv_op_e (funct3 encoding: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
- a  in  XLEN  rs1 operand, sampled on the accept edge
- b  in  XLEN  rs2 operand, sampled on the accept edge
- kill  in  1  abort: pipeline flush or branch mispredict
- in_ready  out  1  high only in IDLE
- busy  out  1  high in CALC and DONE; drives the execute-stage stall
- out_valid  out  1  single-cycle result pulse
- result  out  XLEN  result; valid only while out_valid=1, held otherwise

Behaviour:
- Reset: state=IDLE; in_ready=1; busy=0; out_valid=0; result=0; internal registers=0. Reset is effective immediately, including mid-operation.
- States: muldiv_state_e = IDLE, CALC, DONE.
- IDLE transitions:
  - start=1 and kill=0 moves to CALC and latches op, |a|, |b|, sign flags; iteration counter=0.
  - With EARLY_OUT=1, a divide op with b=0, or DIV/REM with a=0x80000000 and b=0xFFFFFFFF, moves directly to DONE.
- CALC: one iteration per cycle.
  - Multiply: 64-bit accumulator, shift-add on the low multiplier bit.
  - Divide: restoring; remainder shifts left by 1, subtracts the divisor when it does not go negative, and sets the quotient bit.
  - Counter increments each cycle. Counter==XLEN-1 moves to DONE at the next edge.
- DONE (one cycle): out_valid=1 with the sign-fixed result; returns to IDLE at the next edge. A start in DONE is ignored.
- Latency: accepted in cycle 0 gives out_valid in cycle XLEN+1 (33). Early-out cases give out_valid in cycle 1.
- Sign rules:
  - MUL: low XLEN bits.
  - MULH: signed×signed, high half.
  - MULHSU: a signed, b unsigned, high half.
  - MULHU: unsigned, high half.
  - Product is negated when exactly one signed operand is negative.
  - Quotient is negated when the signs of a and b differ (DIV).
  - Remainder takes the sign of a (REM).
- Division special cases (also produced by the loop when EARLY_OUT=0):
  - Divide by zero: DIV/DIVU give all ones; REM/REMU give a.
  - Overflow: DIV gives 0x80000000; REM gives 0.
- kill=1 in CALC or DONE: next edge goes to IDLE with out_valid forced 0 that cycle; the result is discarded.
- start and kill in the same cycle: kill wins; nothing is accepted.
- start while busy: ignored, with no side effects.
- out_valid is never asserted two cycles in a row.

Decomposition:
- Shared package additions: muldiv_op_e (3-bit, funct3 values 0–7), muldiv_state_e, constant MULDIV_LATENCY = XLEN+1.
- Sign-fixup logic (negation plus operand abs) is natural as one combinational sub-module, muldiv_signfix. The FSM and datapath stay in muldiv_seq.

Test Plan:
- MUL a=7, b=0xFFFFFFFD: in_ready falls in cycle 1; out_valid only in cycle 33; result=0xFFFFFFEB.
- High-half multiplies:
  - MULH 0x80000000×0x80000000 gives 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF gives 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF gives 0xFFFFFFFF.
- Divides and remainders:
  - DIV 0xFFFFFFF9/2 gives 0xFFFFFFFD.
  - REM 0xFFFFFFF9/2 gives 0xFFFFFFFF.
  - DIVU 100/7 gives 14.
  - REMU 100/7 gives 2.
  - Each has out_valid in cycle 33.
- EARLY_OUT=1 special cases; each has out_valid in cycle 1; repeat with EARLY_OUT=0 for the same values in cycle 33:
  - DIV 5/0 gives 0xFFFFFFFF.
  - REMU 5/0 gives 5.
  - DIV 0x80000000/0xFFFFFFFF gives 0x80000000.
  - REM of the same operands gives 0.
- Kill and restart:
  - DIVU started, kill pulsed in cycle 10: no out_valid ever; in_ready=1 in cycle 11.
  - A new MUL 3×4 started in cycle 11 returns 12 in cycle 44.
  - start+kill in the same IDLE cycle is not accepted.
- Reset and busy start:
  - reset asserted asynchronously mid-CALC (cycle 5): busy=0, out_valid=0, in_ready=1 before the next clock edge.
  - start pulses during CALC are ignored: exactly one result is produced.
